// File: rtl/sc_chain_bist.sv
// BIST controller for a library-flop shift chain: injects a 16-bit LFSR stream and checks the returned stream.
// Optional MISR signature output is enabled by defining SC_CHAIN_BIST_SIGNATURE_EN.
module sc_chain_bist #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] pattern_len,
  output logic             chain_di,
  input  logic             chain_do,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
  output logic [CNT_W-1:0] first_err,
  output logic [15:0]      signature
`else
  output logic [CNT_W-1:0] first_err
`endif
);

  // j runs through FLUSH, then restarts at RUN entry and keeps counting through DRAIN (up to P+CHAIN_LEN-1).
  localparam int             JW   = CNT_W + $clog2(CHAIN_LEN + 1);
  localparam logic [JW-1:0]  CL_J = JW'(CHAIN_LEN);
  localparam logic [15:0]    SEED = 16'hACE1;

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic [15:0]      gen_q, gen_d;
  logic [15:0]      ref_q, ref_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_err_q, first_err_d;
  logic             pass_q, pass_d;
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
  logic [15:0]      sig_q, sig_d;
`endif

  logic [JW-1:0] p_j;
  logic          in_window;
  logic          mismatch;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // NOTE: every register, state included, clears asynchronously so a mid-test RST aborts immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      plen_q      <= '0;
      gen_q       <= SEED;
      ref_q       <= SEED;
      err_cnt_q   <= '0;
      first_err_q <= '1;
      pass_q      <= 1'b0;
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
      sig_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      plen_q      <= plen_d;
      gen_q       <= gen_d;
      ref_q       <= ref_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
      sig_q       <= sig_d;
`endif
    end
  end

  assign p_j       = JW'(plen_q);
  assign in_window = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                     (j_q >= CL_J) && (j_q < (CL_J + p_j));
  assign mismatch  = in_window && (chain_do != ref_q[0]);

  // NOTE: all next-state values default to their current value first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    plen_d      = plen_q;
    gen_d       = gen_q;
    ref_d       = ref_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
    sig_d       = sig_q;
`endif

    // Compare window: chain_do here carries the bit launched CHAIN_LEN cycles earlier.
    if (in_window) begin
      ref_d = lfsr_next(ref_q);
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
      sig_d = {sig_q[0] ^ sig_q[2] ^ sig_q[3] ^ sig_q[5] ^ chain_do, sig_q[15:1]};
`endif
      if (mismatch) begin
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        if (err_cnt_q == '0)            first_err_d = CNT_W'(j_q - CL_J);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FLUSH;
          j_d         = '0;
          plen_d      = pattern_len;
          gen_d       = SEED;
          ref_d       = SEED;
          err_cnt_d   = '0;
          first_err_d = '1;
          pass_d      = 1'b0;
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
          sig_d       = '0;
`endif
        end
      end
      S_FLUSH: begin
        j_d = j_q + 1'b1;
        if (j_q == CL_J - 1'b1) begin
          j_d     = '0;
          state_d = (plen_q == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        gen_d = lfsr_next(gen_q);
        j_d   = j_q + 1'b1;
        if (j_q == p_j - 1'b1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        j_d = j_q + 1'b1;
        if (j_q == p_j + CL_J - 1'b1) begin
          state_d = S_DONE;
          pass_d  = (err_cnt_d == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // chain_di is combinational so chain latency is exactly CHAIN_LEN flops.
  assign chain_di  = (state_q == S_RUN) && gen_q[0];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
  assign signature = sig_q;
`endif

endmodule

// File: tb/tb_sc_chain_bist.sv
// Self-checking bench for sc_chain_bist: behavioural chain model with fault modes and a bit-list reference model.
// Signature checks are compiled in when SC_CHAIN_BIST_SIGNATURE_EN is defined.
module tb_sc_chain_bist;

  localparam int CL = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] pattern_len;
  logic        chain_di;
  logic        chain_do;
  logic        busy, done, pass;
  logic [15:0] err_cnt, first_err;
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
  logic [15:0] signature;
`endif

  sc_chain_bist #(.CHAIN_LEN(CL), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .pattern_len(pattern_len),
    .chain_di   (chain_di),
    .chain_do   (chain_do),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
    .first_err  (first_err),
    .signature  (signature)
`else
    .first_err  (first_err)
`endif
  );

  always #5 CLK = ~CLK;

  // Chain model: 17 flops; modes pick the tap and any fault.
  localparam int M_OK = 0, M_INV = 1, M_TIE0 = 2, M_D17 = 3;
  logic [16:0] sh;
  int          mode;
  int          tb_cyc = 0;
  int          e0 = 0;
  bit          flips [0:1023];

  always @(posedge CLK) begin
    sh     <= {sh[15:0], chain_di};
    tb_cyc <= tb_cyc + 1;
  end

  always_comb begin
    logic tap;
    int   idx;
    tap = 1'b0;
    case (mode)
      M_OK:    tap = sh[15];
      M_INV:   tap = ~sh[15];
      M_TIE0:  tap = 1'b0;
      M_D17:   tap = sh[16];
      default: tap = sh[15];
    endcase
    // Compare index i is observed in the cycle after edge E0 + 2*CL + i.
    idx = tb_cyc - e0 - 2 * CL;
    chain_do = tap;
    if (idx >= 0 && idx < 1024) chain_do = tap ^ flips[idx];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  task automatic start_dut(input int p);
    @(negedge CLK);
    pattern_len = 16'(p);
    start       = 1'b1;
    @(posedge CLK);
    #1;
    e0          = tb_cyc;
    start       = 1'b0;
    pattern_len = 16'($urandom);
  endtask

  task automatic run_test(input string nm, input int m, input int p, input bit noise);
    bit          g  [$];
    bit          rx [$];
    logic [15:0] v;
    int          exp_err, exp_first, lat;
    logic [15:0] exp_sig;
    bit          seen;

    // Reference: the bits sent, the bits the chain returns, then the error tally.
    v = 16'hACE1;
    for (int i = 0; i < p; i++) begin
      g.push_back(v[0]);
      v = lfsr_step(v);
    end
    for (int i = 0; i < p; i++) begin
      bit b;
      case (m)
        M_INV:   b = !g[i];
        M_TIE0:  b = 1'b0;
        M_D17:   b = (i == 0) ? 1'b0 : g[i-1];
        default: b = g[i];
      endcase
      rx.push_back(b ^ flips[i]);
    end
    exp_err   = 0;
    exp_first = 16'hFFFF;
    exp_sig   = 16'h0000;
    for (int i = 0; i < p; i++) begin
      if (rx[i] != g[i]) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
      exp_sig = {exp_sig[0] ^ exp_sig[2] ^ exp_sig[3] ^ exp_sig[5] ^ rx[i], exp_sig[15:1]};
    end

    mode = m;
    start_dut(p);
    check({nm, ".busy"}, 32'(busy), 32'd1);

    seen = 1'b0;
    lat  = -1;
    for (int c = 0; c < 2 * CL + p + 10; c++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        lat  = tb_cyc - e0;
        break;
      end
      if (noise) begin
        start       = ($urandom_range(2) == 0);
        pattern_len = 16'($urandom);
      end
    end
    if (!seen) begin
      check({nm, ".timeout"}, 32'(seen), 32'd1);
      start = 1'b0;
      return;
    end
    check({nm, ".latency"}, 32'(lat), 32'(2 * CL + p));
    check({nm, ".pass"}, 32'(pass), 32'(exp_err == 0));
    check({nm, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check({nm, ".first_err"}, 32'(first_err), 32'(exp_first));
`ifdef SC_CHAIN_BIST_SIGNATURE_EN
    check({nm, ".signature"}, 32'(signature), 32'(exp_sig));
`endif
    // A start seen in DONE must not launch a new test.
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    @(negedge CLK);
    check({nm, ".done_pulse"}, 32'(done), 32'd0);
    check({nm, ".idle_after"}, 32'(busy), 32'd0);
    check({nm, ".pass_hold"}, 32'(pass), 32'(exp_err == 0));
  endtask

  task automatic clear_flips();
    for (int i = 0; i < 1024; i++) flips[i] = 1'b0;
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, ".busy"}, 32'(busy), 32'd0);
    check({nm, ".done"}, 32'(done), 32'd0);
    check({nm, ".pass"}, 32'(pass), 32'd0);
    check({nm, ".err_cnt"}, 32'(err_cnt), 32'd0);
    check({nm, ".first_err"}, 32'(first_err), 32'hFFFF);
    check({nm, ".chain_di"}, 32'(chain_di), 32'd0);
  endtask

  initial begin
    int done_seen;
    RST         = 1'b1;
    start       = 1'b0;
    pattern_len = '0;
    mode        = M_OK;
    clear_flips();
    #1;
    check_reset_values("rst");
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    run_test("ok100",  M_OK,   100, 1'b0);
    run_test("inv100", M_INV,  100, 1'b0);
    run_test("tie32",  M_TIE0, 32,  1'b0);
    run_test("d17",    M_D17,  200, 1'b0);
    run_test("p0",     M_OK,   0,   1'b0);
    run_test("noise",  M_OK,   77,  1'b1);

    // Asynchronous reset at j=50 of a P=100 run.
    mode = M_OK;
    start_dut(100);
    while (tb_cyc - e0 < CL + 50) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check_reset_values("abort");
    @(negedge CLK);
    RST = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 2 * CL + 120; c++) begin
      @(negedge CLK);
      if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    run_test("after_abort", M_OK, 100, 1'b0);

    // Randomised runs with sparse injected bit errors on top of each chain mode.
    for (int r = 0; r < 8; r++) begin
      int m, p;
      m = $urandom_range(3);
      p = $urandom_range(300);
      clear_flips();
      for (int i = 0; i < p; i++) flips[i] = ($urandom_range(15) == 0);
      run_test($sformatf("rnd%0d", r), m, p, r[0]);
    end
    clear_flips();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
